// File: rtl/axi_lite_mem_master.sv
// Bridges a core req/gnt/rvalid memory port to an AXI4-Lite master, one transaction in flight.
// Read and write completions both return on rvalid_o; error responses feed a saturating counter.
//
// state   | meaning
// IDLE    | waiting for req_i, grant is combinational
// RD_ADDR | ARVALID held until ARREADY
// RD_DATA | RREADY high, waiting for RVALID
// WR_REQ  | AWVALID/WVALID each held until their own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RESP    | one-cycle rvalid_o pulse, no grant
module axi_lite_mem_master #(
  parameter int         ADDR_WIDTH    = 32,
  parameter int         DATA_WIDTH    = 32,
  parameter logic [2:0] AXI_PROT      = 3'b000,
  parameter int         ERR_CNT_WIDTH = 16,
  localparam int        STRB          = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic                     we_i,
  input  logic [STRB-1:0]          be_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic                     rvalid_o,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     err_o,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic                     m_axi_arvalid,
  output logic [2:0]               m_axi_arprot,
  input  logic                     m_axi_arready,
  input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic                     m_axi_awvalid,
  output logic [2:0]               m_axi_awprot,
  input  logic                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [STRB-1:0]          m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic                     busy_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [STRB-1:0]          be_q, be_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          // Byte offset is dropped here; sub-word access is expressed by be_i only.
          addr_d    = addr_i & ~ADDR_WIDTH'(3);
          be_d      = be_i;
          wdata_d   = wdata_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = we_i ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          err_d   = m_axi_rresp[1];
          state_d = RESP;
        end
      end
      WR_REQ: begin
        if (m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          err_d   = m_axi_bresp[1];
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o         = req_i && (state_q == IDLE) && !rst;
  assign rvalid_o      = (state_q == RESP);
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign busy_o        = (state_q != IDLE);
  assign err_count_o   = err_cnt_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == RD_ADDR);
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_rready  = (state_q == RD_DATA);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = be_q;
  assign m_axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axi_bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Bench for axi_lite_mem_master: a small AXI-Lite slave memory with programmable
// ready/valid delays and response codes, driven on the falling edge.
module tb_axi_lite_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic        busy_o;
  logic [1:0]  err_count_o;

  axi_lite_mem_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_PROT(3'b100), .ERR_CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arprot(m_axi_arprot),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awprot(m_axi_awprot), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .busy_o(busy_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_rv  = 0;

  // slave configuration
  int       ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  // slave state
  logic [31:0] mem [0:63];
  logic        slv_rst = 1'b1;
  logic        ar_hs = 1'b0, r_hs = 1'b0, aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0;
  logic [31:0] sl_araddr = '0, sl_awaddr = '0, sl_wdata = '0;
  logic [2:0]  sl_arprot = '0, sl_awprot = '0;
  logic [3:0]  sl_wstrb = '0;
  logic        rd_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  // per-cycle trace of the most recent transaction
  logic        tr_awv [0:63];
  logic        tr_wv  [0:63];
  logic        araddr_bad;

  always @(negedge clk) if (rvalid_o) n_rv++;

  always @(posedge clk) begin
    slv_rst = rst;
    ar_hs = m_axi_arvalid && m_axi_arready;
    r_hs  = m_axi_rvalid  && m_axi_rready;
    aw_hs = m_axi_awvalid && m_axi_awready;
    w_hs  = m_axi_wvalid  && m_axi_wready;
    b_hs  = m_axi_bvalid  && m_axi_bready;
    if (ar_hs) begin sl_araddr = m_axi_araddr; sl_arprot = m_axi_arprot; end
    if (aw_hs) begin sl_awaddr = m_axi_awaddr; sl_awprot = m_axi_awprot; end
    if (w_hs)  begin sl_wdata = m_axi_wdata; sl_wstrb = m_axi_wstrb; end
  end

  always @(negedge clk) begin
    if (slv_rst) begin
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_awready = 1'b0;
      m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (ar_hs) begin
        m_axi_arready = 1'b0; ar_cnt = 0; rd_pend = 1'b1; r_cnt = 0;
      end else if (m_axi_arvalid && !m_axi_arready) begin
        if (ar_cnt >= ar_delay) m_axi_arready = 1'b1; else ar_cnt++;
      end
      if (r_hs) begin
        m_axi_rvalid = 1'b0; rd_pend = 1'b0;
      end else if (rd_pend && !m_axi_rvalid) begin
        if (r_cnt >= r_delay) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = mem[sl_araddr[7:2]]; m_axi_rresp = rresp_cfg;
        end else r_cnt++;
      end
      if (aw_hs) begin
        m_axi_awready = 1'b0; aw_cnt = 0; aw_got = 1'b1;
      end else if (m_axi_awvalid && !m_axi_awready) begin
        if (aw_cnt >= aw_delay) m_axi_awready = 1'b1; else aw_cnt++;
      end
      if (w_hs) begin
        m_axi_wready = 1'b0; w_cnt = 0; w_got = 1'b1;
      end else if (m_axi_wvalid && !m_axi_wready) begin
        if (w_cnt >= w_delay) m_axi_wready = 1'b1; else w_cnt++;
      end
      if (b_hs) begin
        m_axi_bvalid = 1'b0; b_pend = 1'b0;
      end else if (aw_got && w_got && !b_pend) begin
        for (int b = 0; b < 4; b++)
          if (sl_wstrb[b]) mem[sl_awaddr[7:2]][8*b +: 8] = sl_wdata[8*b +: 8];
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = 0;
      end
      if (b_pend && !m_axi_bvalid) begin
        if (b_cnt >= b_delay) begin
          m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg;
        end else b_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request, release req_i after the grant edge, and wait for rvalid_o.
  // lat counts falling edges from the grant cycle to the rvalid_o cycle.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic got;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
    #1;
    chk({tag, "_gnt"}, gnt_o, 1'b1);
    @(posedge clk);
    #1;
    req_i = 1'b0; addr_i = 32'hDEAD_BEEF; wdata_i = ~wd; be_i = 4'h0; we_i = ~we;
    got = 1'b0; lat = 0; rd = '0; er = 1'b0; araddr_bad = 1'b0;
    for (int c = 0; c < 64; c++) begin tr_awv[c] = 1'b0; tr_wv[c] = 1'b0; end
    for (int c = 1; c < 64 && !got; c++) begin
      @(negedge clk);
      tr_awv[c] = m_axi_awvalid;
      tr_wv[c]  = m_axi_wvalid;
      if (m_axi_arvalid && m_axi_araddr !== (addr & 32'hFFFF_FFFC)) araddr_bad = 1'b1;
      if (rvalid_o) begin got = 1'b1; lat = c; rd = rdata_o; er = err_o; end
    end
    chk({tag, "_rvalid_seen"}, got, 1'b1);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_ax;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          rv0;
  logic [7:0]  g_tr, rv_tr;
  logic        seen_rready;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,          32'h1000_0113, 32'h00, 4'h0};
    vecs[1] = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,          32'h0010_0093, 32'h04, 4'h0};
    vecs[2] = '{1'b1, 32'h0000_0070, 4'hF, 32'h0000_00FF,  32'h0010_0093, 32'h70, 4'hF};
    vecs[3] = '{1'b0, 32'h0000_0070, 4'h0, 32'h0,          32'h0000_00FF, 32'h70, 4'h0};
    vecs[4] = '{1'b1, 32'h0000_0070, 4'h4, 32'hAABB_CCDD,  32'h0000_00FF, 32'h70, 4'h4};
    vecs[5] = '{1'b0, 32'h0000_0070, 4'h0, 32'h0,          32'h00BB_00FF, 32'h70, 4'h0};
    vecs[6] = '{1'b1, 32'h0000_0072, 4'h8, 32'h1122_3344,  32'h00BB_00FF, 32'h70, 4'h8};
    vecs[7] = '{1'b0, 32'h0000_0073, 4'h0, 32'h0,          32'h11BB_00FF, 32'h70, 4'h0};

    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h1000_0113;
    mem[1] = 32'h0010_0093;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_axi_valids", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 5'b0);
    chk("rst_outputs", {gnt_o, rvalid_o, err_o, busy_o}, 4'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err_count", err_count_o, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // zero-wait directed vectors
    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), er, 1'b0);
      chk($sformatf("v%0d_latency", i), lat, 3);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_awaddr", i), sl_awaddr, vecs[i].exp_ax);
        chk($sformatf("v%0d_wstrb", i), sl_wstrb, vecs[i].exp_strb);
        chk($sformatf("v%0d_wdata", i), sl_wdata, vecs[i].wdata);
        chk($sformatf("v%0d_awprot", i), sl_awprot, 3'b100);
      end else begin
        chk($sformatf("v%0d_araddr", i), sl_araddr, vecs[i].exp_ax);
        chk($sformatf("v%0d_arprot", i), sl_arprot, 3'b100);
      end
    end

    // back-to-back reads with req_i held: one grant per 4 cycles, none during RESP
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4;
    for (int c = 0; c < 8; c++) begin
      #1;
      g_tr[c] = gnt_o;
      rv_tr[c] = rvalid_o;
      if (c == 7) req_i = 1'b0;
      @(negedge clk);
    end
    chk("b2b_gnt_pattern", g_tr, 8'b0001_0001);
    chk("b2b_rvalid_pattern", rv_tr, 8'b1000_1000);
    repeat (2) @(negedge clk);

    // read backpressure
    ar_delay = 5; r_delay = 3;
    rv0 = n_rv;
    do_txn("bp_rd", 1'b0, 32'h0000_0004, 4'h0, 32'h0, rd, er, lat);
    chk("bp_rd_rdata", rd, 32'h0010_0093);
    chk("bp_rd_latency", lat, 11);
    chk("bp_rd_araddr_stable", araddr_bad, 1'b0);
    chk("bp_rd_pulses", n_rv - rv0, 1);
    ar_delay = 0; r_delay = 0;

    // write with AW accepted 4 cycles after W
    aw_delay = 4;
    rv0 = n_rv;
    do_txn("bp_wr", 1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, rd, er, lat);
    chk("bp_wr_latency", lat, 7);
    chk("bp_wr_c1_aw_w", {tr_awv[1], tr_wv[1]}, 2'b11);
    chk("bp_wr_c2_aw_w", {tr_awv[2], tr_wv[2]}, 2'b10);
    chk("bp_wr_c5_aw_w", {tr_awv[5], tr_wv[5]}, 2'b10);
    chk("bp_wr_c6_aw_w", {tr_awv[6], tr_wv[6]}, 2'b00);
    chk("bp_wr_pulses", n_rv - rv0, 1);
    aw_delay = 0;
    do_txn("bp_rb", 1'b0, 32'h0000_0040, 4'h0, 32'h0, rd, er, lat);
    chk("bp_rb_rdata", rd, 32'h1234_5678);

    // reset while waiting in RD_DATA
    r_delay = 5;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    seen_rready = 1'b0;
    for (int c = 0; c < 20 && !seen_rready; c++) begin
      @(negedge clk);
      if (m_axi_rready) seen_rready = 1'b1;
    end
    chk("rst_mid_reached_rd_data", seen_rready, 1'b1);
    rst = 1'b1;
    rv0 = n_rv;
    @(posedge clk);
    #1;
    chk("rst_mid_valids", {m_axi_arvalid, m_axi_rready, busy_o}, 3'b000);
    chk("rst_mid_rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    r_delay = 0;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_pulse", n_rv - rv0, 0);
    do_txn("post_rst", 1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat);
    chk("post_rst_rdata", rd, 32'h1000_0113);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_err", er, 1'b0);

    // error responses and saturation of the 2-bit counter
    rresp_cfg = 2'b10;
    do_txn("err_rd", 1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat);
    chk("err_rd_err", er, 1'b1);
    rresp_cfg = 2'b00; bresp_cfg = 2'b11;
    do_txn("err_wr", 1'b1, 32'h0000_0080, 4'hF, 32'h5555_AAAA, rd, er, lat);
    chk("err_wr_err", er, 1'b1);
    chk("err_count_two", err_count_o, 2'd2);
    bresp_cfg = 2'b00; rresp_cfg = 2'b10;
    do_txn("err3", 1'b0, 32'h4, 4'h0, 32'h0, rd, er, lat);
    chk("err_count_three", err_count_o, 2'd3);
    do_txn("err4", 1'b0, 32'h4, 4'h0, 32'h0, rd, er, lat);
    do_txn("err5", 1'b0, 32'h4, 4'h0, 32'h0, rd, er, lat);
    chk("err_count_saturated", err_count_o, 2'd3);
    rresp_cfg = 2'b00;
    do_txn("ok_after_err", 1'b0, 32'h4, 4'h0, 32'h0, rd, er, lat);
    chk("ok_after_err_err", er, 1'b0);
    chk("ok_after_err_rdata", rd, 32'h0010_0093);
    chk("ok_after_err_count", err_count_o, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
